cordic_vectoring: RTL and testbench

CORDIC_VECTORING -- requirements
Module: cordic_vectoring

---
 rtl/cordic_vectoring.sv | 127 ++++++++++++
 tb/tb_cordic_vectoring.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_vectoring.sv
// CORDIC vectoring engine: turns an unsigned (cos, sin) pair into a
// first-quadrant angle (90/256-degree code) and a gain-compensated magnitude.
module cordic_vectoring #(
  parameter int ITERS = 8,
  parameter int IW    = 12
) (
  input  logic       CLK,
  input  logic       RESET_PULSE,
  input  logic       START,
  input  logic [7:0] X_IN,
  input  logic [7:0] Y_IN,
  output logic [7:0] ANGLE,
  output logic [8:0] MAG,
  output logic       BUSY,
  output logic       READY
);

  // One fractional guard bit (at IW=12) keeps the floor error of the
  // arithmetic shifts from piling up in x; the largest x (~1200) still fits.
  localparam int unsigned GUARD = IW - 11;
  localparam int unsigned ZW    = 10;
  localparam logic [2:0]  LAST  = 3'(ITERS - 1);

  typedef enum logic [1:0] {IDLE, ITER, SCALE, DONE} state_t;

  state_t               state;
  logic signed [IW-1:0] x, y;
  logic signed [ZW-1:0] z;
  logic        [2:0]    i;
  logic                 zero_r;
  logic                 scale_ph;
  logic        [8:0]    mag_r;
  logic        [7:0]    ang_r;

  logic signed [IW-1:0] x_sh_c, y_sh_c, mag_c;
  logic signed [ZW-1:0] t_c;
  logic        [7:0]    ang_c;

  // Elementary-angle table, same 90/256-degree code as ANGLE.
  function automatic logic signed [ZW-1:0] atan_lut(input logic [2:0] idx);
    case (idx)
      3'd0:    atan_lut = 10'sd128;
      3'd1:    atan_lut = 10'sd76;
      3'd2:    atan_lut = 10'sd40;
      3'd3:    atan_lut = 10'sd20;
      3'd4:    atan_lut = 10'sd10;
      3'd5:    atan_lut = 10'sd5;
      3'd6:    atan_lut = 10'sd3;
      default: atan_lut = 10'sd1;
    endcase
  endfunction

  // Shifted operands, table angle, gain compensation and angle clamp.
  always_comb begin
    x_sh_c = x >>> i;
    y_sh_c = y >>> i;
    t_c    = atan_lut(i);
    mag_c  = (x >>> 1) + (x >>> 3) - (x >>> 6) - (x >>> 9);
    ang_c  = 8'd0;
    if (zero_r || z < 0)      ang_c = 8'd0;
    else if (z > 10'sd255)    ang_c = 8'd255;
    else                      ang_c = z[7:0];
  end

  // Control FSM and datapath; SCALE spends one cycle compensating, one publishing.
  always_ff @(posedge CLK) begin
    if (!RESET_PULSE) begin
      state    <= IDLE;
      x        <= '0;
      y        <= '0;
      z        <= '0;
      i        <= '0;
      zero_r   <= 1'b0;
      scale_ph <= 1'b0;
      mag_r    <= '0;
      ang_r    <= '0;
      ANGLE    <= '0;
      MAG      <= '0;
      BUSY     <= 1'b0;
      READY    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (START) begin
            x        <= IW'(X_IN) << GUARD;
            y        <= IW'(Y_IN) << GUARD;
            z        <= '0;
            i        <= '0;
            zero_r   <= (X_IN == 8'd0) && (Y_IN == 8'd0);
            scale_ph <= 1'b0;
            READY    <= 1'b0;
            BUSY     <= 1'b1;
            state    <= ITER;
          end
        end
        ITER: begin
          if (!y[IW-1]) begin
            x <= x + y_sh_c;
            y <= y - x_sh_c;
            z <= z + t_c;
          end else begin
            x <= x - y_sh_c;
            y <= y + x_sh_c;
            z <= z - t_c;
          end
          i <= i + 3'd1;
          if (i == LAST) state <= SCALE;
        end
        SCALE: begin
          if (!scale_ph) begin
            mag_r    <= 9'(mag_c >>> GUARD);
            ang_r    <= ang_c;
            scale_ph <= 1'b1;
          end else begin
            ANGLE <= ang_r;
            MAG   <= mag_r;
            READY <= 1'b1;
            BUSY  <= 1'b0;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_vectoring.sv
// Self-checking bench for cordic_vectoring: scoreboard of ideal atan2/hypot
// results, compared with tolerance when READY rises.
module tb_cordic_vectoring;

  logic       CLK = 1'b0;
  logic       RESET_PULSE;
  logic       START;
  logic [7:0] X_IN, Y_IN;
  logic [7:0] ANGLE;
  logic [8:0] MAG;
  logic       BUSY, READY;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    int angle;
    int mag;
    int tol;
  } exp_t;

  exp_t sb[$];

  localparam real PI = 3.14159265358979;

  cordic_vectoring dut (
    .CLK(CLK), .RESET_PULSE(RESET_PULSE), .START(START),
    .X_IN(X_IN), .Y_IN(Y_IN), .ANGLE(ANGLE), .MAG(MAG),
    .BUSY(BUSY), .READY(READY)
  );

  always #5 CLK = ~CLK;

  // Ideal first-quadrant result, clamped to the 8-bit angle code.
  function automatic exp_t ideal(input int x, input int y, input int tol);
    exp_t e;
    real  a;
    e.tol = tol;
    if (x == 0 && y == 0) begin
      e.angle = 0;
      e.mag   = 0;
    end else begin
      a = $atan2(real'(y), real'(x)) * 512.0 / PI;
      e.angle = (a > 255.0) ? 255 : int'(a);
      e.mag   = int'($sqrt(real'(x * x + y * y)));
    end
    return e;
  endfunction

  // Pulse START for one edge; returns at the negedge after the accepting edge.
  task automatic start_conv(input int x, input int y, input int tol, input bit push);
    if (push) sb.push_back(ideal(x, y, tol));
    START = 1'b1;
    X_IN  = 8'(x);
    Y_IN  = 8'(y);
    @(posedge CLK);
    @(negedge CLK);
    START = 1'b0;
  endtask

  task automatic wait_ready(input int budget, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge CLK);
      if (READY === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic sb_pop(output exp_t e, output bit ok);
    ok = (sb.size() != 0);
    if (ok) e = sb.pop_front();
    else    e = '{angle: -1, mag: -1, tol: 0};
  endtask

  task automatic test_reset();
    RESET_PULSE = 1'b0;
    START = 1'b1; X_IN = 8'd100; Y_IN = 8'd100;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    vectors++;
    if (BUSY !== 1'b0 || READY !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_priority busy=%b ready=%b required busy=0 ready=0", BUSY, READY);
    end
    RESET_PULSE = 1'b1;
    START = 1'b0;
    @(negedge CLK);
    vectors++;
    if ({ANGLE, MAG, BUSY, READY} !== 19'd0) begin
      miscompares++;
      $display("FAIL reset_state angle=%0d mag=%0d busy=%b ready=%b required all 0",
               ANGLE, MAG, BUSY, READY);
    end
    repeat (5) @(negedge CLK);
    vectors++;
    if ({ANGLE, MAG, BUSY, READY} !== 19'd0) begin
      miscompares++;
      $display("FAIL reset_idle_hold angle=%0d mag=%0d busy=%b ready=%b required all 0",
               ANGLE, MAG, BUSY, READY);
    end
  endtask

  // BUSY after edges k+1..k+9, READY after k+10, optional ignored START at k+5.
  task automatic test_latency(input int x, input int y, input int inj_at);
    exp_t e;
    bit   ok;
    start_conv(x, y, 2, 1'b1);
    for (int n = 1; n <= 9; n++) begin
      @(negedge CLK);
      vectors++;
      if (BUSY !== 1'b1 || READY !== 1'b0) begin
        miscompares++;
        $display("FAIL latency_busy edge k+%0d busy=%b ready=%b required busy=1 ready=0",
                 n, BUSY, READY);
      end
      if (n == inj_at) begin
        START = 1'b1; X_IN = 8'd10; Y_IN = 8'd240;
      end else if (n == inj_at + 1) begin
        START = 1'b0;
      end
    end
    START = 1'b0;
    @(negedge CLK);
    vectors++;
    if (READY !== 1'b1 || BUSY !== 1'b0) begin
      miscompares++;
      $display("FAIL latency_ready edge k+10 busy=%b ready=%b required busy=0 ready=1",
               BUSY, READY);
    end
    sb_pop(e, ok);
    vectors++;
    if (!ok || int'(ANGLE) > e.angle + e.tol || int'(ANGLE) < e.angle - e.tol) begin
      miscompares++;
      $display("FAIL latency_angle x=%0d y=%0d angle=%0d required %0d+-%0d",
               x, y, ANGLE, e.angle, e.tol);
    end
    vectors++;
    if (!ok || int'(MAG) > e.mag + e.tol || int'(MAG) < e.mag - e.tol) begin
      miscompares++;
      $display("FAIL latency_mag x=%0d y=%0d mag=%0d required %0d+-%0d",
               x, y, MAG, e.mag, e.tol);
    end
  endtask

  task automatic test_vectors();
    int   tx[5]  = '{71, 100, 0, 0, 200};
    int   ty[5]  = '{245, 0, 200, 0, 50};
    int   tol[5] = '{2, 2, 0, 0, 2};
    exp_t e;
    bit   ok;
    for (int k = 0; k < 5; k++) begin
      start_conv(tx[k], ty[k], tol[k], 1'b1);
      wait_ready(20, ok);
      vectors++;
      if (!ok) begin
        miscompares++;
        $display("FAIL vec_timeout x=%0d y=%0d ready=%b required 1 within 20 cycles",
                 tx[k], ty[k], READY);
      end
      sb_pop(e, ok);
      vectors++;
      if (!ok || int'(ANGLE) > e.angle + e.tol || int'(ANGLE) < e.angle - e.tol) begin
        miscompares++;
        $display("FAIL vec_angle x=%0d y=%0d angle=%0d required %0d+-%0d",
                 tx[k], ty[k], ANGLE, e.angle, e.tol);
      end
      vectors++;
      if (!ok || int'(MAG) > e.mag + e.tol || int'(MAG) < e.mag - e.tol) begin
        miscompares++;
        $display("FAIL vec_mag x=%0d y=%0d mag=%0d required %0d+-%0d",
                 tx[k], ty[k], MAG, e.mag, e.tol);
      end
    end
  endtask

  task automatic test_done_hold();
    exp_t e;
    bit   ok;
    start_conv(100, 0, 2, 1'b1);
    wait_ready(20, ok);
    sb_pop(e, ok);
    X_IN = 8'd33; Y_IN = 8'd77;
    repeat (5) @(negedge CLK);
    vectors++;
    if (READY !== 1'b1 || BUSY !== 1'b0 || int'(ANGLE) > e.angle + e.tol ||
        int'(MAG) > e.mag + e.tol || int'(MAG) < e.mag - e.tol) begin
      miscompares++;
      $display("FAIL done_hold ready=%b angle=%0d mag=%0d required ready=1 angle=%0d mag=%0d +-%0d",
               READY, ANGLE, MAG, e.angle, e.mag, e.tol);
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    start_conv(200, 50, 2, 1'b0);
    repeat (3) @(negedge CLK);
    RESET_PULSE = 1'b0;
    START = 1'b1; X_IN = 8'd100; Y_IN = 8'd100;
    @(posedge CLK);
    @(negedge CLK);
    vectors++;
    if ({ANGLE, MAG, BUSY, READY} !== 19'd0) begin
      miscompares++;
      $display("FAIL reset_mid angle=%0d mag=%0d busy=%b ready=%b required all 0",
               ANGLE, MAG, BUSY, READY);
    end
    RESET_PULSE = 1'b1;
    START = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 12; n++) begin
      @(negedge CLK);
      if (READY !== 1'b0 || BUSY !== 1'b0) seen = 1'b1;
    end
    vectors++;
    if (seen) begin
      miscompares++;
      $display("FAIL reset_mid_abort activity=%b required 0 (no result after abort)", seen);
    end
    test_latency(71, 245, 0);
  endtask

  task automatic test_back_to_back();
    exp_t e;
    bit   ok;
    start_conv(0, 200, 0, 1'b1);
    wait_ready(20, ok);
    sb_pop(e, ok);
    vectors++;
    if (!ok || int'(ANGLE) != e.angle || int'(MAG) > e.mag + 2 || int'(MAG) < e.mag - 2) begin
      miscompares++;
      $display("FAIL b2b_first angle=%0d mag=%0d required %0d / %0d+-2",
               ANGLE, MAG, e.angle, e.mag);
    end
    start_conv(100, 100, 2, 1'b1);
    vectors++;
    if (READY !== 1'b0 || BUSY !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_accept ready=%b busy=%b required ready=0 busy=1", READY, BUSY);
    end
    wait_ready(20, ok);
    sb_pop(e, ok);
    vectors++;
    if (!ok || int'(ANGLE) > e.angle + e.tol || int'(ANGLE) < e.angle - e.tol ||
        int'(MAG) > e.mag + e.tol || int'(MAG) < e.mag - e.tol) begin
      miscompares++;
      $display("FAIL b2b_second angle=%0d mag=%0d required %0d / %0d +-%0d",
               ANGLE, MAG, e.angle, e.mag, e.tol);
    end
  endtask

  initial begin
    RESET_PULSE = 1'b1;
    START = 1'b0;
    X_IN  = 8'd0;
    Y_IN  = 8'd0;
    test_reset();
    test_latency(100, 100, 0);
    test_vectors();
    test_done_hold();
    test_latency(200, 50, 4);
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
